// File: rtl/timer_pkg.sv
// timer_pkg: shared state encoding, register offsets and CTRL field layout for timer_device.
package timer_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;
  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;
  localparam int CTRL_EN   = 0;
  localparam int CTRL_MODE = 1;
  localparam int CTRL_IM   = 3;
  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;
endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: emits one tick every PRESCALE cycles; restart realigns the phase to zero.
module timer_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);
  logic [31:0] cnt;
  assign tick = cnt == PRESCALE - 1;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= (restart || tick) ? '0 : cnt + 1;
endmodule

// File: rtl/timer_device.sv
// timer_device: memory-mapped countdown timer with masked IRQ output.
// Define TIMER_PRESCALE_EN to slow the countdown by PRESCALE cycles per decrement.
module timer_device
  import timer_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);
  logic [3:0]  ctrl;
  logic [31:0] preset, count;
  logic        irq_flag, tick, wr_ctrl, wr_preset, unused;
  state_t      state;
  assign wr_ctrl   = we && byteen == 4'hF && addr[3:2] == OFF_CTRL;
  assign wr_preset = we && byteen == 4'hF && addr[3:2] == OFF_PRESET;
  assign irq = ctrl[CTRL_IM] & irq_flag;
  assign rdata = addr[3:2] == OFF_CTRL   ? {28'b0, ctrl} :
                 addr[3:2] == OFF_PRESET ? preset :
                 addr[3:2] == OFF_COUNT  ? count  : '0;
`ifdef TIMER_PRESCALE_EN
  timer_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk(clk), .reset(reset), .restart(state == LOAD || we), .tick(tick)
  );
  assign unused = ^{addr[31:4], addr[1:0]};
`else
  assign tick = 1'b1;
  assign unused = ^{addr[31:4], addr[1:0], PRESCALE};
`endif
  // The flag rises together with the move into INT so irq appears N+2 cycles after the enabling write.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ctrl     <= '0;
      preset   <= '0;
      count    <= '0;
      irq_flag <= 1'b0;
      state    <= IDLE;
    end else if (wr_ctrl || wr_preset) begin
      if (wr_ctrl) ctrl <= wdata[3:0];
      if (wr_preset) preset <= wdata;
      irq_flag <= 1'b0;
      state    <= IDLE;
    end else
      case (state)
        IDLE: if (ctrl[CTRL_EN]) state <= LOAD;
        LOAD: begin
          count <= preset;
          state <= CNT;
        end
        CNT:
          if (!ctrl[CTRL_EN]) state <= IDLE;
          else if (tick) begin
            if (count > 1) count <= count - 1;
            else begin
              count    <= '0;
              irq_flag <= 1'b1;
              state    <= INT;
            end
          end
        INT: begin
          if (ctrl[CTRL_MODE +: 2] == MODE_RELOAD) irq_flag <= 1'b0;
          else ctrl[CTRL_EN] <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule
